// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// This block sends one command byte to the device over the open-drain PS2Clk
// and PS2Data lines. The top level turns each *_oe output into a pull-down,
// where oe=1 drives the line low and oe=0 releases it to the pull-up.
// While `busy` is high the PS/2 receive path ignores the lines.
//
// Ports:
//   clk          in   system clock (100 MHz)
//   rst          in   asynchronous reset, active high
//   tx_data[7:0] in   byte to send, sampled when tx_start is accepted
//   tx_start     in   single-cycle request, ignored while busy
//   ps2_clk_i    in   raw PS2Clk pad (asynchronous)
//   ps2_data_i   in   raw PS2Data pad (asynchronous)
//   ps2_clk_oe   out  1 = drive PS2Clk low
//   ps2_data_oe  out  1 = drive PS2Data low
//   busy         out  transfer in progress
//   done         out  one-cycle pulse at the end of a transfer
//   ack_ok       out  device acknowledged the last transfer
//   err_timeout  out  the last transfer timed out
//
// State    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | lines released, waiting for tx_start
// INHIBIT  | PS2Clk held low for INHIBIT_CYCLES
// REQ      | PS2Clk and PS2Data both low for 16 cycles (request to send)
// SEND     | PS2Clk released; one frame bit shifted per device falling edge
// WAIT_REL | waiting for the device to release both lines
// DONE     | one-cycle completion pulse

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 12000,
  parameter int START_TIMEOUT_CYCLES = 1500000,
  parameter int XFER_TIMEOUT_CYCLES  = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int REQ_CYCLES = 16;
  localparam int MAX_A = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                 : START_TIMEOUT_CYCLES;
  localparam int MAX_B = (MAX_A > XFER_TIMEOUT_CYCLES) ? MAX_A : XFER_TIMEOUT_CYCLES;
  localparam int MAX_C = (MAX_B > REQ_CYCLES) ? MAX_B : REQ_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] INH_LOAD   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] REQ_LOAD   = CW'(REQ_CYCLES - 1);
  localparam logic [CW-1:0] START_LOAD = CW'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] XFER_LOAD  = CW'(XFER_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT   = 4'd10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INHIBIT  = 3'd1,
    REQ      = 3'd2,
    SEND     = 3'd3,
    WAIT_REL = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    n_q, n_d;
  logic [10:0]   frame_q, frame_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;
  logic clk_fall;

  // Synchronizers reset to the idle-high line level so that leaving reset
  // cannot produce a false falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_i;
      data_s2_q  <= data_s1_q;
    end
  end

  assign clk_fall = clk_prev_q & ~clk_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      frame_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      frame_q   <= frame_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    frame_d = frame_q;
    ack_d   = ack_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          // frame bit n: 0 = start, 1..8 = data LSB first, 9 = odd parity, 10 = stop
          frame_d = {1'b1, ~^tx_data, tx_data, 1'b0};
          ack_d   = 1'b0;
          err_d   = 1'b0;
          cnt_d   = INH_LOAD;
          state_d = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt_q == '0) begin
          cnt_d   = REQ_LOAD;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      REQ: begin
        if (cnt_q == '0) begin
          cnt_d   = START_LOAD;
          n_d     = '0;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      SEND: begin
        if (clk_fall && (n_q == '0)) begin
          // First device edge restarts the timer with the whole-transfer budget.
          cnt_d = XFER_LOAD;
          n_d   = 4'd1;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          ack_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (clk_fall) begin
            if (n_q == LAST_BIT) begin
              ack_d   = ~data_s2_q;
              state_d = WAIT_REL;
            end else begin
              n_d = n_q + 4'd1;
            end
          end
        end
      end

      WAIT_REL: begin
        if (clk_s2_q && data_s2_q) begin
          state_d = DONE;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          ack_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Pad controls and status flags are decoded from the next state and
    // registered, so they line up with state_q and never glitch.
    clk_oe_d  = (state_d == INHIBIT) || (state_d == REQ);
    data_oe_d = (state_d == REQ) || ((state_d == SEND) && !frame_d[n_d]);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_ok      = ack_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH = 200;
  localparam int STO = 1000;
  localparam int XTO = 2000;
  localparam int H   = 40;
  localparam int LIM = 4 * XTO;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ps2_clk_i, ps2_data_i;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_ok, err_timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  // Open-drain lines with pull-ups: low if either side pulls.
  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES      (INH),
    .START_TIMEOUT_CYCLES(STO),
    .XFER_TIMEOUT_CYCLES (XTO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device model: samples the data line at the end of each high phase,
  // then generates the falling edge; optional ACK before edge 11.
  task automatic bfm(input int n_edges, input bit give_ack, output logic [10:0] bits);
    bits = '0;
    for (int i = 0; i < n_edges; i++) begin
      repeat (H) @(negedge clk);
      bits[i] = ps2_data_i;
      if (i == 10 && give_ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_send(input string tag);
    int k = 0;
    while (!(busy && !ps2_clk_oe && ps2_data_oe) && k < LIM) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_send_reached"}, 32'(k < LIM), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < LIM) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [10:0] bits);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_start"},  32'(bits[0]),   32'd0);
      check({tag, "_data"},   32'(bits[8:1]), 32'(e));
      check({tag, "_parity"}, 32'(bits[9]),   32'(~^e));
      check({tag, "_stop"},   32'(bits[10]),  32'd1);
    end
  endtask

  // Ends on the negedge where done is high.
  task automatic run_frame(input string tag, input bit give_ack, input bit exp_ack);
    logic [10:0] bits;
    wait_send(tag);
    bfm(11, give_ack, bits);
    check_frame(tag, bits);
    wait_done(tag);
    check({tag, "_ack_ok"}, 32'(ack_ok), 32'(exp_ack));
    check({tag, "_err"},    32'(err_timeout), 32'd0);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits;
    int k;
    int c_edge;
    int dn;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({busy, done, ack_ok, err_timeout, ps2_clk_oe, ps2_data_oe}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: 0xF4 with ACK, inhibit and request phase lengths
    start_tx(8'hF4);
    exp_q.push_back(8'hF4);
    k = 0;
    while (ps2_clk_oe && !ps2_data_oe && k < LIM) begin
      @(negedge clk);
      k++;
    end
    check("t1_inhibit_len", 32'(k), 32'(INH));
    check("t1_req_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b11);
    k = 0;
    while (ps2_clk_oe && k < LIM) begin
      @(negedge clk);
      k++;
    end
    check("t1_req_len", 32'(k), 32'd16);
    run_frame("t1", 1'b1, 1'b1);
    after_done("t1");

    // 2: 0xFF with ACK withheld
    repeat (5) @(negedge clk);
    start_tx(8'hFF);
    exp_q.push_back(8'hFF);
    run_frame("t2", 1'b0, 1'b0);
    after_done("t2");

    // 3: device never clocks
    repeat (5) @(negedge clk);
    start_tx(8'h12);
    wait_send("t3");
    k = 0;
    while (ps2_data_oe && k < LIM) begin
      @(negedge clk);
      k++;
    end
    check("t3_start_timeout_len", 32'(k), 32'(STO));
    check("t3_oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_err", 32'(err_timeout), 32'd1);
    check("t3_ack", 32'(ack_ok), 32'd0);
    after_done("t3");

    // 4: device stops after edge 5
    repeat (5) @(negedge clk);
    start_tx(8'hF4);
    wait_send("t4");
    c_edge = cyc + H;
    bfm(5, 1'b0, bits);
    wait_done("t4");
    check("t4_xfer_timeout_len", 32'(cyc - c_edge), 32'(XTO + 3));
    check("t4_err", 32'(err_timeout), 32'd1);
    check("t4_ack", 32'(ack_ok), 32'd0);
    check("t4_oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    after_done("t4");

    // 5: request while busy ignored; DONE-cycle request ignored; next accepted
    repeat (5) @(negedge clk);
    start_tx(8'hF4);
    exp_q.push_back(8'hF4);
    repeat (10) @(negedge clk);
    start_tx(8'hAA);
    run_frame("t5a", 1'b1, 1'b1);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    check("t5_done_cycle_start_ignored", 32'({done, busy}), 32'd0);
    tx_data = 8'hAA;
    @(negedge clk);
    tx_start = 1'b0;
    check("t5_idle_start_accepted", 32'(busy), 32'd1);
    exp_q.push_back(8'hAA);
    run_frame("t5b", 1'b1, 1'b1);
    after_done("t5b");

    // 6: reset mid-transfer, then a clean send
    repeat (5) @(negedge clk);
    start_tx(8'hF4);
    wait_send("t6");
    bfm(4, 1'b0, bits);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_reset", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      dn += 32'(done);
    end
    check("t6_no_done_on_reset", 32'(dn), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    start_tx(8'hF4);
    exp_q.push_back(8'hF4);
    run_frame("t6b", 1'b1, 1'b1);
    after_done("t6b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
